serial_adder: RTL
=================

// Module: serial_adder
// PURPOSE
//  Parametrised multi-cycle adder; successor to the combinational half/full adder cells.
//  Adds two WIDTH-bit operands DIGIT bits per clock through one DIGIT-bit adder slice and a carry flop.
//  Trades latency for area in the ALU datapath. Valid/ready handshake on input and output.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; >= 1
//  DIGIT  1  bits added per cycle; WIDTH % DIGIT == 0 required (else $error at elaboration)
// PORTS
//  clk         in   1      single clock, rising edge
//  reset       in   1      synchronous, active-high reset
//  inA         in   WIDTH  operand A, sampled on start handshake
//  inB         in   WIDTH  operand B, sampled on start handshake
//  carryIn     in   1      carry into bit 0, sampled on start handshake
//  startValid  in   1      operands present
//  startReady  out  1      block can accept operands
//  sum         out  WIDTH  result, stable while outValid=1
//  carry       out  1      carry out of bit WIDTH-1, stable while outValid=1
//  outValid    out  1      result present
//  outReady    in   1      consumer takes result
// BEHAVIOUR
//  - Reset: state=IDLE, sum=0, carry=0, outValid=0, startReady=1, step counter=0, operand regs=0.
//  - FSM IDLE -> RUN on startValid&&startReady: latch inA, inB, carryIn; clear counter.
//  - RUN: each cycle adds A[k*DIGIT+:DIGIT] + B[k*DIGIT+:DIGIT] + carryReg;
//    writes the low DIGIT bits into sum slice k, carry-out into carryReg; k++.
//  - RUN -> DONE after step k = WIDTH/DIGIT-1; carry = final carryReg; outValid=1 in DONE.
//  - Latency: start handshake in cycle 0 -> outValid high from cycle WIDTH/DIGIT+1 (9 for defaults).
//  - DONE: sum/carry/outValid hold until outValid&&outReady.
//  - startReady = (state==IDLE) || (state==DONE && outReady): back-to-back allowed.
//    Simultaneous result take + new start in DONE -> RUN directly; outValid drops next cycle.
//  - DONE + outReady without startValid -> IDLE; sum/carry keep last values (not cleared).
//  - startValid held in RUN/DONE is ignored until startReady; inputs are not sampled early.
//  - Sum slices not yet written during RUN are undefined to the consumer (outValid=0).
//  - Arithmetic modulo 2^WIDTH; carry = bit WIDTH of inA+inB+carryIn.
//  - Reset in any state, incl. mid-RUN: aborts the operation, restores reset values next edge;
//    no partial result is ever presented.
//  - DIGIT == WIDTH: one RUN cycle; latency 2.
// CONFIGURATION
//  SERIAL_ADDER_SUB_EN defined: extra port subtract (in, 1), sampled on start handshake.
//    subtract=1 computes inA - inB: B latched as ~inB; carry into bit 0 forced to 1 (carryIn ignored);
//    carry = NOT borrow (1 when inA >= inB, unsigned). subtract=0 behaves exactly as without the macro.
//  SERIAL_ADDER_SUB_EN undefined: no subtract port; add only.
// TESTING (WIDTH=8, DIGIT=1 unless noted; each check also records an allPassed flag)
//  T0 reset: reset=1 for 2 cycles -> outValid=0, startReady=1, sum=0x00, carry=0.
//  T1 add: A=0x0F, B=0x01, cin=0 -> outValid exactly 9 cycles after handshake; sum=0x10, carry=0.
//  T2 wrap: A=0xFF, B=0x01, cin=0 -> sum=0x00, carry=1; A=0xFF, B=0xFF, cin=1 -> sum=0xFF, carry=1.
//  T3 backpressure + back-to-back: hold outReady=0 for 5 cycles -> sum/carry stable, startReady=0;
//    then outReady=1 with startValid=1 (A=0x22, B=0x11) -> RUN next cycle; result 0x33, carry 0.
//  T4 reset mid-op: start A=0xAA, B=0x55, assert reset at step 4 -> IDLE, outValid never rises,
//    next op A=0x01, B=0x02 -> sum=0x03.
//  T5 DIGIT=4 / SERIAL_ADDER_SUB_EN: add A=0x9C, B=0x75 -> latency 3, sum=0x11, carry=1;
//    sub A=0x05, B=0x07 -> sum=0xFE, carry=0; sub A=0x07, B=0x05 -> sum=0x02, carry=1.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder. Adds two WIDTH-bit operands DIGIT bits per clock
// through one DIGIT-bit adder slice and a carry flop, with valid/ready on both sides.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a 'subtract' port (inA - inB).
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             carryIn,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             subtract,
`endif
    input  logic             startValid,
    output logic             startReady,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             outValid,
    input  logic             outReady
);

    localparam int unsigned Steps = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
    localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;

    if (WIDTH == 0 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           r_state, w_state_d;
    logic [WIDTH-1:0] r_a, w_a_d;
    logic [WIDTH-1:0] r_b, w_b_d;
    logic [WIDTH-1:0] r_sum, w_sum_d;
    logic             r_carry, w_carry_d;
    logic [CntW-1:0]  r_cnt, w_cnt_d;

    logic [WIDTH-1:0] w_b_load;
    logic             w_cin_load;
    logic [DIGIT:0]   w_step;
    logic             w_start;
    logic             w_last;

    // Operand B and carry-in as latched on the start handshake.
`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction as A + ~B + 1; the final carry is then NOT borrow.
    assign w_b_load   = subtract ? ~inB : inB;
    assign w_cin_load = subtract ? 1'b1 : carryIn;
`else
    assign w_b_load   = inB;
    assign w_cin_load = carryIn;
`endif

    assign startReady = (r_state == StIdle) || ((r_state == StDone) && outReady);
    assign w_start    = startValid && startReady;
    assign w_last     = (r_cnt == CntW'(Steps - 1));

    assign sum      = r_sum;
    assign carry    = r_carry;
    assign outValid = (r_state == StDone);

    // One DIGIT-bit adder slice; operands are shifted right so the active slice is always low.
    always_comb begin
        w_step = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
    end

    // Next-state and datapath update.
    always_comb begin
        w_state_d = r_state;
        w_a_d     = r_a;
        w_b_d     = r_b;
        w_sum_d   = r_sum;
        w_carry_d = r_carry;
        w_cnt_d   = r_cnt;

        unique case (r_state)
            StIdle: ;
            StRun: begin
                w_a_d     = r_a >> DIGIT;
                w_b_d     = r_b >> DIGIT;
                // Result slices enter at the top and reach their final place after Steps shifts.
                w_sum_d   = (r_sum >> DIGIT) | (WIDTH'(w_step[DIGIT-1:0]) << (WIDTH - DIGIT));
                w_carry_d = w_step[DIGIT];
                if (w_last) begin
                    w_state_d = StDone;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StDone: begin
                if (outReady) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase

        // A start handshake (from IDLE, or DONE with the result taken) overrides the above.
        if (w_start) begin
            w_state_d = StRun;
            w_a_d     = inA;
            w_b_d     = w_b_load;
            w_carry_d = w_cin_load;
            w_cnt_d   = '0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_a     <= w_a_d;
            r_b     <= w_b_d;
            r_sum   <= w_sum_d;
            r_carry <= w_carry_d;
            r_cnt   <= w_cnt_d;
        end
    end

endmodule
